dmem_wbuf: RTL and testbench

Store write buffer between the single-cycle core's data port and the data memory. It captures byte-lane stores from the core (`daddr`/`dwdata`/`dwe`) into a small FIFO and drains them to memory over a valid/ready handshake, so the core does not wait on slow memory writes. Loads read memory combinationally, and any bytes still pending in the buffer are forwarded, so the core always sees program-order data. A stall output holds the core when the buffer is full.

---
 rtl/dmem_wbuf_if.sv | 27 ++
 rtl/dmem_wbuf.sv | 98 +++++++++
 tb/tb_dmem_wbuf.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_wbuf_if.sv
// Core data port and memory write port bundle for the store write buffer.
// The slave modport is the buffer side, and the master modport is the core/memory environment.
interface dmem_wbuf_if;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [3:0]  dwe;
    logic [31:0] drdata;
    logic        stall;
    logic        empty;
    logic [31:0] m_raddr;
    logic [31:0] m_rdata;
    logic        m_valid;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_we;
    logic        m_ready;

    modport slave (
        input  daddr, dwdata, dwe, m_rdata, m_ready,
        output drdata, stall, empty, m_raddr, m_valid, m_addr, m_wdata, m_we
    );

    modport master (
        output daddr, dwdata, dwe, m_rdata, m_ready,
        input  drdata, stall, empty, m_raddr, m_valid, m_addr, m_wdata, m_we
    );
endinterface

// File: rtl/dmem_wbuf.sv
// Store write buffer: FIFO of byte-lane stores drained to memory, with load forwarding.
// Store visible to memory 1 cycle after enqueue; stall when full, never combinational from m_ready.
module dmem_wbuf #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    dmem_wbuf_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [29:0] waddr;
        logic [31:0] data;
        logic [3:0]  be;
    } entry_t;

    entry_t        fifo_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;

    logic          full;
    logic          enq;
    logic          deq;
    logic [AW-1:0] idx;
    logic [31:0]   fwd;
    entry_t        head;
    logic          unused_ok;

    assign full = (count_q == (AW+1)'(DEPTH));
    assign enq  = reset && (bus.dwe != 4'b0000) && !full;
    assign deq  = (count_q != '0) && bus.m_ready;
    assign head = fifo_q[rptr_q];

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (enq) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (deq) begin
            rptr_d = rptr_q + AW'(1);
        end
        if (enq && !deq) begin
            count_d = count_q + (AW+1)'(1);
        end else if (deq && !enq) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Entry storage carries no reset: contents are only meaningful under count_q.
    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_q[wptr_q] <= '{waddr: bus.daddr[31:2], data: bus.dwdata, be: bus.dwe};
        end
    end

    // Walk oldest to youngest so the youngest matching entry owns each lane.
    always_comb begin
        fwd = bus.m_rdata;
        idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rptr_q + AW'(i);
            if (reset && ((AW+1)'(i) < count_q) && (fifo_q[idx].waddr == bus.daddr[31:2])) begin
                for (int b = 0; b < 4; b++) begin
                    if (fifo_q[idx].be[b]) begin
                        fwd[8*b +: 8] = fifo_q[idx].data[8*b +: 8];
                    end
                end
            end
        end
    end

    assign bus.drdata  = fwd;
    assign bus.stall   = reset && (bus.dwe != 4'b0000) && full;
    assign bus.empty   = (count_q == '0);
    assign bus.m_raddr = {bus.daddr[31:2], 2'b00};
    assign bus.m_valid = (count_q != '0);
    assign bus.m_addr  = {head.waddr, 2'b00};
    assign bus.m_wdata = head.data;
    assign bus.m_we    = head.be;

    assign unused_ok = &{1'b0, bus.daddr[1:0]};
endmodule

// File: tb/tb_dmem_wbuf.sv
// Scoreboarded bench for dmem_wbuf: memory model, program-order shadow memory for loads.
// Accepted stores are queued as expected memory writes and checked on each drain handshake.
module tb_dmem_wbuf;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic mem_load = 1'b1;

    always #5 clk = ~clk;

    dmem_wbuf_if bus ();

    dmem_wbuf #(.DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } exp_t;

    logic [31:0] mem  [256];
    logic [31:0] arch [256];
    exp_t        sb [$];
    int          n_vec = 0;
    int          n_err = 0;
    int          last_stalls = 0;

    function automatic logic [31:0] pattern(input int i);
        logic [31:0] p;
        p = 32'hC0DE_0000 | 32'(i);
        if (i == 128) p = 32'h1122_3344;
        return p;
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    assign bus.m_rdata = mem[bus.m_raddr[9:2]];

    // Memory model: accepts the head whenever valid and ready meet on an edge.
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 256; i++) mem[i] <= pattern(i);
        end else if (reset && bus.m_valid && bus.m_ready) begin
            for (int b = 0; b < 4; b++)
                if (bus.m_we[b]) mem[bus.m_addr[9:2]][8*b +: 8] <= bus.m_wdata[8*b +: 8];
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (reset && bus.m_valid && bus.m_ready) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("drain_addr", bus.m_addr, e.addr);
                chk("drain_data", bus.m_wdata, e.data);
                chk("drain_be", {28'd0, bus.m_we}, {28'd0, e.be});
            end
        end
    end

    task automatic arch_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        for (int b = 0; b < 4; b++)
            if (be[b]) arch[a[9:2]][8*b +: 8] = d[8*b +: 8];
    endtask

    // Holds the store until the buffer takes it; called at posedge+1.
    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        int tries = 0;
        bus.daddr = a; bus.dwdata = d; bus.dwe = be;
        @(negedge clk);
        while (bus.stall && tries < 20) begin
            tries++;
            @(negedge clk);
        end
        last_stalls = tries;
        if (bus.stall) begin
            chk("store_timeout", 32'd1, 32'd0);
        end else begin
            sb.push_back('{a & 32'hFFFF_FFFC, d, be});
            arch_wr(a, d, be);
        end
        @(posedge clk); #1;
        bus.dwe = 4'b0000;
    endtask

    task automatic load(input string tag, input logic [31:0] a);
        bus.dwe = 4'b0000; bus.daddr = a;
        @(negedge clk);
        chk(tag, bus.drdata, arch[a[9:2]]);
        chk("raddr", bus.m_raddr, a & 32'hFFFF_FFFC);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n = 0;
        bus.m_ready = 1'b1;
        while (bus.m_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        bus.m_ready = 1'b0;
        chk("drain_empty", {31'd0, bus.empty}, 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) arch[i] = pattern(i);
        bus.daddr = '0; bus.dwdata = '0; bus.dwe = '0; bus.m_ready = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_valid", {31'd0, bus.m_valid}, 32'd0);
        chk("rst_empty", {31'd0, bus.empty}, 32'd1);
        @(posedge clk); #1;
        mem_load = 1'b0;
        reset = 1'b1;

        // Single store, held head, then drain
        store(32'h104, 32'h00AB_0000, 4'b0100);
        @(negedge clk);
        chk("single_valid", {31'd0, bus.m_valid}, 32'd1);
        chk("single_addr", bus.m_addr, 32'h104);
        chk("single_be", {28'd0, bus.m_we}, 32'h4);
        chk("single_empty", {31'd0, bus.empty}, 32'd0);
        @(posedge clk); #1;
        chk("single_hold", bus.m_wdata, 32'h00AB_0000);
        load("single_fwd", 32'h104);
        chk("single_fwd_k", arch[32'h104 >> 2], 32'hC0AB_0041);
        bus.m_ready = 1'b1;
        @(posedge clk); #1;
        bus.m_ready = 1'b0;
        @(negedge clk);
        chk("single_drained", {31'd0, bus.empty}, 32'd1);
        @(posedge clk); #1;

        // Fill to DEPTH, fifth store stalls until one entry drains
        for (int i = 0; i < 4; i++) store(32'(4 * i), 32'h1000_0000 + 32'(i), 4'hF);
        bus.m_ready = 1'b1;
        bus.daddr = 32'h10; bus.dwdata = 32'h5A5A_0005; bus.dwe = 4'hF;
        @(negedge clk);
        chk("fill_stall", {31'd0, bus.stall}, 32'd1);
        @(posedge clk); #1;
        bus.m_ready = 1'b0;
        @(negedge clk);
        chk("fill_unstall", {31'd0, bus.stall}, 32'd0);
        sb.push_back('{32'h10, 32'h5A5A_0005, 4'hF});
        arch_wr(32'h10, 32'h5A5A_0005, 4'hF);
        @(posedge clk); #1;
        bus.dwe = 4'b0000;
        @(negedge clk);
        chk("fill_head", bus.m_addr, 32'h4);
        chk("fill_full_stall", {31'd0, bus.stall}, 32'd0);
        @(posedge clk); #1;
        load("fill_fwd", 32'h10);
        drain();

        // Forwarding merge, youngest entry per lane
        store(32'h200, 32'h0000_00AA, 4'b0001);
        store(32'h200, 32'h0000_BBCC, 4'b0011);
        load("merge", 32'h200);
        chk("merge_k", arch[32'h200 >> 2], 32'h1122_BBCC);
        store(32'h202, 32'hDD00_0000, 4'b1000);
        load("merge_hi", 32'h200);
        load("other_word", 32'h204);
        drain();
        load("merge_mem", 32'h200);

        // Simultaneous enqueue/dequeue with pointer wrap
        store(32'h300, 32'h3000_0000, 4'hF);
        store(32'h304, 32'h3000_0001, 4'hF);
        bus.m_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            store(32'h308 + 32'(4 * i), 32'h3100_0000 + 32'(i), (i % 2 == 0) ? 4'hF : 4'b0110);
            chk("simul_nostall", 32'(last_stalls), 32'd0);
        end
        @(negedge clk);
        chk("simul_cnt2", {31'd0, bus.m_valid}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("simul_cnt1", {31'd0, bus.m_valid}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("simul_cnt0", {31'd0, bus.m_valid}, 32'd0);
        @(posedge clk); #1;
        bus.m_ready = 1'b0;
        for (int i = 0; i < 12; i++) load("simul_mem", 32'h300 + 32'(4 * i));

        // Reset mid-operation with three pending stores
        store(32'h100, 32'h5555_AAAA, 4'hF);
        store(32'h104, 32'h6666_BBBB, 4'hF);
        store(32'h108, 32'h7777_CCCC, 4'hF);
        reset = 1'b0;
        bus.daddr = 32'h100; bus.dwdata = 32'h1; bus.dwe = 4'hF;
        #1;
        chk("mid_rst_valid", {31'd0, bus.m_valid}, 32'd0);
        chk("mid_rst_empty", {31'd0, bus.empty}, 32'd1);
        chk("mid_rst_stall", {31'd0, bus.stall}, 32'd0);
        chk("mid_rst_rdata", bus.drdata, 32'hC0DE_0040);
        sb.delete();
        for (int i = 0; i < 256; i++) arch[i] = mem[i];
        @(posedge clk); #1;
        bus.dwe = 4'b0000;
        reset = 1'b1;
        load("post_rst", 32'h100);
        chk("post_rst_k", bus.drdata, 32'hC0DE_0040);
        chk("post_rst_empty", {31'd0, bus.empty}, 32'd1);

        chk("sb_left", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
